// File: rtl/vdf_output_reducer_if.sv
// Handshake bundle for vdf_output_reducer: the operand pair goes in, the reduced square comes out.
// master = producer/consumer side, slave = reducer side.
interface vdf_output_reducer_if #(
  parameter int unsigned MOD_LEN = 1024
);
  logic                 in_valid;
  logic                 in_ready;
  logic [MOD_LEN+34:0]  sqa_in;
  logic [MOD_LEN+34:0]  sqb_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [MOD_LEN-1:0]   sq_out;

  modport master (
    output in_valid,
    output sqa_in,
    output sqb_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sq_out
  );

  modport slave (
    input  in_valid,
    input  sqa_in,
    input  sqb_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sq_out
  );
endinterface

// File: rtl/vdf_output_reducer.sv
// Limb-serial canonical reduction: sq_out = (sqa_in + sqb_in) mod MODULUS, one LIMB_W slice per cycle.
// Optional range self-check after reduction, enabled by VDF_REDUCER_SELFCHECK_EN.
module vdf_output_reducer #(
  parameter int unsigned        MOD_LEN = 1024,
  parameter logic [MOD_LEN-1:0] MODULUS = {1'b1, {(MOD_LEN-2){1'b0}}, 1'b1},
  parameter int unsigned        LIMB_W  = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
`ifdef VDF_REDUCER_SELFCHECK_EN
  output logic                   range_err,
`endif
  vdf_output_reducer_if.slave    bus_io
);

  localparam int unsigned OPW      = MOD_LEN + 35;
  localparam int unsigned SW       = MOD_LEN + 36;
  localparam int unsigned NLIMB    = (SW + LIMB_W - 1) / LIMB_W;
  localparam int unsigned PW       = NLIMB * LIMB_W;
  localparam int unsigned NSHIFT   = 37;
  localparam int unsigned ShiftW   = 6;
  localparam int unsigned LimbCntW = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  // Modulus pre-padded with NSHIFT-1 zeros below it: the limb of (MODULUS << k) at limb i
  // is the LIMB_W-bit window starting at i*LIMB_W + (NSHIFT-1-k).
  localparam logic [PW+NSHIFT-2:0] MPad =
    {{(PW-MOD_LEN){1'b0}}, MODULUS, {(NSHIFT-1){1'b0}}};

  if (!MODULUS[MOD_LEN-1]) begin : g_modulus_msb_check
    $error("vdf_output_reducer: MODULUS[MOD_LEN-1] must be 1");
  end

  typedef enum logic [2:0] {
    StIdle,
    StAdd,
    StReduce,
    StCheck,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         s_q, s_d;
  // Holds operand B during ADD, then the trial difference D during REDUCE.
  logic [PW-1:0]         b_q, b_d;
  logic                  cb_q, cb_d;
  logic [LimbCntW-1:0]   limb_q, limb_d;
  logic [ShiftW-1:0]     shift_q, shift_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [MOD_LEN-1:0]    sq_out_q, sq_out_d;
`ifdef VDF_REDUCER_SELFCHECK_EN
  logic                  range_err_q, range_err_d;
`endif

  logic [31:0]           limb_base;
  logic [31:0]           mod_base;
  logic [LIMB_W-1:0]     s_limb;
  logic [LIMB_W-1:0]     b_limb;
  logic [LIMB_W-1:0]     m_limb;
  logic [LIMB_W:0]       add_w;
  logic [LIMB_W:0]       sub_w;
  logic                  last_limb;
  logic                  last_shift;

  assign limb_base  = 32'(limb_q) * LIMB_W;
  assign mod_base   = limb_base + 32'(shift_q);
  assign s_limb     = s_q[limb_base +: LIMB_W];
  assign b_limb     = b_q[limb_base +: LIMB_W];
  assign m_limb     = MPad[mod_base +: LIMB_W];
  assign add_w      = {1'b0, s_limb} + {1'b0, b_limb} + {{LIMB_W{1'b0}}, cb_q};
  // Bit LIMB_W of the (LIMB_W+1)-bit difference is the outgoing borrow.
  assign sub_w      = {1'b0, s_limb} - {1'b0, m_limb} - {{LIMB_W{1'b0}}, cb_q};
  assign last_limb  = (limb_q == LimbCntW'(NLIMB - 1));
  assign last_shift = (shift_q == ShiftW'(NSHIFT - 1));

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    b_d         = b_q;
    cb_d        = cb_q;
    limb_d      = limb_q;
    shift_d     = shift_q;
    out_valid_d = out_valid_q;
    sq_out_d    = sq_out_q;
`ifdef VDF_REDUCER_SELFCHECK_EN
    range_err_d = range_err_q;
`endif

    case (state_q)
      StIdle: begin
        if (bus_io.in_valid && in_ready_q) begin
          s_d     = {{(PW-OPW){1'b0}}, bus_io.sqa_in};
          b_d     = {{(PW-OPW){1'b0}}, bus_io.sqb_in};
          cb_d    = 1'b0;
          limb_d  = '0;
          shift_d = '0;
          state_d = StAdd;
`ifdef VDF_REDUCER_SELFCHECK_EN
          range_err_d = 1'b0;
`endif
        end
      end

      StAdd: begin
        s_d[limb_base +: LIMB_W] = add_w[LIMB_W-1:0];
        cb_d   = add_w[LIMB_W];
        limb_d = limb_q + LimbCntW'(1);
        if (last_limb) begin
          cb_d    = 1'b0;
          limb_d  = '0;
          shift_d = '0;
          state_d = StReduce;
        end
      end

      StReduce: begin
        b_d[limb_base +: LIMB_W] = sub_w[LIMB_W-1:0];
        cb_d   = sub_w[LIMB_W];
        limb_d = limb_q + LimbCntW'(1);
        if (last_limb) begin
          cb_d   = 1'b0;
          limb_d = '0;
          if (!sub_w[LIMB_W]) begin
            s_d = b_d;
          end
          if (last_shift) begin
`ifdef VDF_REDUCER_SELFCHECK_EN
            state_d = StCheck;
`else
            state_d = StDone;
`endif
          end else begin
            shift_d = shift_q + ShiftW'(1);
          end
        end
      end

      StCheck: begin
`ifdef VDF_REDUCER_SELFCHECK_EN
        // shift_q is still NSHIFT-1 here, so m_limb walks the unshifted modulus.
        cb_d   = sub_w[LIMB_W];
        limb_d = limb_q + LimbCntW'(1);
        if (last_limb) begin
          cb_d        = 1'b0;
          limb_d      = '0;
          range_err_d = ~sub_w[LIMB_W];
          state_d     = StDone;
        end
`else
        state_d = StIdle;
`endif
      end

      StDone: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          sq_out_d    = s_q[MOD_LEN-1:0];
        end else if (bus_io.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    in_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cb_q        <= 1'b0;
      limb_q      <= '0;
      shift_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sq_out_q    <= '0;
`ifdef VDF_REDUCER_SELFCHECK_EN
      range_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cb_q        <= cb_d;
      limb_q      <= limb_d;
      shift_q     <= shift_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sq_out_q    <= sq_out_d;
`ifdef VDF_REDUCER_SELFCHECK_EN
      range_err_q <= range_err_d;
`endif
    end
  end

  // Wide datapath registers are only meaningful after an accept, so they carry no reset.
  always_ff @(posedge clk) begin
    s_q <= s_d;
    b_q <= b_d;
  end

  assign bus_io.in_ready  = in_ready_q;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.sq_out    = sq_out_q;
`ifdef VDF_REDUCER_SELFCHECK_EN
  assign range_err        = range_err_q;
`endif

endmodule

// File: tb/tb_vdf_output_reducer.sv
// Self-checking bench for vdf_output_reducer on a reduced 128-bit modulus with 32-bit limbs.
// Expected results come from a wide-integer (a + b) % MODULUS model.
module tb_vdf_output_reducer;

  localparam int unsigned        MOD_LEN = 128;
  localparam int unsigned        LIMB_W  = 32;
  localparam logic [MOD_LEN-1:0] MODULUS = 128'hC3A5_1F27_9B4D_6E81_0F5A_2C7D_93B1_E64B;
  localparam int unsigned        OPW     = MOD_LEN + 35;
  localparam int unsigned        NLIMB   = (MOD_LEN + 36 + LIMB_W - 1) / LIMB_W;
`ifdef VDF_REDUCER_SELFCHECK_EN
  localparam int                 LAT     = 1 + 39 * NLIMB;
`else
  localparam int                 LAT     = 1 + 38 * NLIMB;
`endif
  localparam int                 NRAND   = 60;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
`ifdef VDF_REDUCER_SELFCHECK_EN
  logic range_err;
`endif

  int checks   = 0;
  int failures = 0;

  vdf_output_reducer_if #(.MOD_LEN(MOD_LEN)) bus ();

  vdf_output_reducer #(
    .MOD_LEN (MOD_LEN),
    .MODULUS (MODULUS),
    .LIMB_W  (LIMB_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef VDF_REDUCER_SELFCHECK_EN
    .range_err (range_err),
`endif
    .bus_io    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [MOD_LEN-1:0] golden(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    logic [255:0] s;
    s = 256'(a) + 256'(b);
    return MOD_LEN'(s % 256'(MODULUS));
  endfunction

  function automatic logic [OPW-1:0] rand_op();
    logic [191:0] r;
    for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom;
    return r[OPW-1:0];
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic drive_accept(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input string tag);
    int g = 0;
    while (bus.in_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_ready"}, 256'(bus.in_ready), 256'(1));
    bus.sqa_in   = a;
    bus.sqb_in   = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Called right after the accept edge; returns at the negedge where out_valid is first seen.
  task automatic await_result(input logic [MOD_LEN-1:0] exp, input string tag);
    int lat = 0;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && lat < 2 * LAT) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 256'(lat), 256'(LAT));
    check({tag, "_data"}, 256'(bus.sq_out), 256'(exp));
    check({tag, "_busy"}, 256'(bus.in_ready), 256'(0));
`ifdef VDF_REDUCER_SELFCHECK_EN
    check({tag, "_range_err"}, 256'(range_err), 256'(0));
`endif
  endtask

  task automatic handshake(input logic [MOD_LEN-1:0] exp, input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_valid_drop"}, 256'(bus.out_valid), 256'(0));
    check({tag, "_held"}, 256'(bus.sq_out), 256'(exp));
  endtask

  task automatic run_pair(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input string tag);
    logic [MOD_LEN-1:0] exp;
    exp = golden(a, b);
    drive_accept(a, b, tag);
    await_result(exp, tag);
    handshake(exp, tag);
  endtask

  initial begin
    logic [OPW-1:0]     m_ext;
    logic [OPW-1:0]     ones;
    logic [OPW-1:0]     a;
    logic [OPW-1:0]     b;
    logic [OPW-1:0]     a2;
    logic [OPW-1:0]     b2;
    logic [MOD_LEN-1:0] exp;
    int                 seen;

    m_ext         = OPW'(MODULUS);
    ones          = '1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.sqa_in    = '0;
    bus.sqb_in    = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", 256'(bus.in_ready), 256'(0));
    check("rst_out_valid", 256'(bus.out_valid), 256'(0));
    check("rst_sq_out", 256'(bus.sq_out), 256'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // Zero pair, exact latency
    run_pair('0, '0, "zero");

    // Boundaries around the modulus
    run_pair(m_ext - OPW'(1), OPW'(1), "m_minus1_plus1");
    run_pair(m_ext - OPW'(1), '0, "m_minus1_plus0");
    check("m_minus1_value", 256'(bus.sq_out), 256'(MODULUS - MOD_LEN'(1)));

    // Largest operands
    run_pair(ones, ones, "all_ones");

    // Output held under back-pressure; input ignored until handshake completes
    a  = rand_op();
    b  = rand_op();
    a2 = rand_op();
    b2 = rand_op();
    exp = golden(a, b);
    drive_accept(a, b, "hold");
    await_result(exp, "hold");
    bus.sqa_in   = a2;
    bus.sqb_in   = b2;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("hold_valid", 256'(bus.out_valid), 256'(1));
      check("hold_data", 256'(bus.sq_out), 256'(exp));
      check("hold_in_ready", 256'(bus.in_ready), 256'(0));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check("late_idle_ready", 256'(bus.in_ready), 256'(1));
    check("late_valid_drop", 256'(bus.out_valid), 256'(0));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    await_result(golden(a2, b2), "late_accept");
    handshake(golden(a2, b2), "late_accept");

    // Reset in the middle of REDUCE aborts the operation
    drive_accept(rand_op(), rand_op(), "abort");
    repeat (100) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_rst_ready", 256'(bus.in_ready), 256'(0));
    check("abort_rst_valid", 256'(bus.out_valid), 256'(0));
    check("abort_rst_sq_out", 256'(bus.sq_out), 256'(0));
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    check("abort_no_output", 256'(seen), 256'(0));
    run_pair(rand_op(), rand_op(), "after_abort");

    // Random back-to-back pairs
    for (int n = 0; n < NRAND; n++) begin
      a = rand_op();
      b = rand_op();
      if (n % 10 == 3) a = m_ext * OPW'($urandom_range(1, 1000));
      if (n % 10 == 7) b = ones - OPW'($urandom);
      run_pair(a, b, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
